seg7_bin2bcd: RTL and testbench

Sequential binary-to-BCD converter that sits directly upstream of the 8-digit seven-segment display driver. It takes a 32-bit unsigned binary value from the CPU's memory-mapped I/O write path and converts it to eight packed BCD digits using iterative shift-add-3 (double-dabble). It then presents the result on a 32-bit data bus together with a one-cycle chip-select strobe, which the display driver latches. Decimal rather than hex display is thereby a drop-in stage between the MMIO decoder and the display.

---
 rtl/seg7_pkg.sv | 7 +
 rtl/bcd_digit_adj.sv | 7 +
 rtl/seg7_bin2bcd.sv | 61 ++++++
 tb/tb_seg7_bin2bcd.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared FSM encoding and constants for the binary-to-BCD display stage
package seg7_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  localparam logic [31:0] BCD_LIMIT = 32'd100_000_000;
  localparam logic [31:0] BCD_ERR = 32'hEEEE_EEEE;
  localparam int BCD_DIGITS = 8;
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: double-dabble add-3 correction for one BCD digit
module bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adj
);
  always_comb adj = digit >= 4'd5 ? digit + 4'd3 : digit;
endmodule

// File: rtl/seg7_bin2bcd.sv
// seg7_bin2bcd: 32-bit binary to 8-digit packed BCD via iterative shift-add-3,
// strobing each new result to the seven-segment display driver
module seg7_bin2bcd
  import seg7_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic [31:0] i_bin,
  output logic        o_busy,
  output logic [31:0] o_data,
  output logic        o_cs,
  output logic        o_ovf
);
  state_t state, state_nx;
  logic [31:0] bin_r, bcd_r, bcd_adj;
  logic [63:0] sh;
  logic [5:0] cnt;
  logic ovf_r;
  for (genvar d = 0; d < BCD_DIGITS; d++) begin : g_adj
    bcd_digit_adj u_adj (.digit(bcd_r[4*d+:4]), .adj(bcd_adj[4*d+:4]));
  end
  // the top bit of the corrected accumulator falls off; only overflow inputs reach it
  assign sh = {bcd_adj, bin_r} << 1;
  assign o_busy = state != IDLE;
  always_comb begin
    state_nx = IDLE;
    if (state == IDLE) state_nx = i_start ? SHIFT : IDLE;
    else if (state == SHIFT) state_nx = cnt == 6'd31 ? DONE : SHIFT;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      bin_r <= '0;
      bcd_r <= '0;
      cnt <= '0;
      ovf_r <= 1'b0;
      o_data <= '0;
      o_cs <= 1'b0;
      o_ovf <= 1'b0;
    end else begin
      state <= state_nx;
      o_cs <= state == DONE;
      if (state == IDLE && i_start) begin
        bin_r <= i_bin;
        bcd_r <= '0;
        cnt <= '0;
        ovf_r <= i_bin >= BCD_LIMIT;
      end
      if (state == SHIFT) begin
        bcd_r <= sh[63:32];
        bin_r <= sh[31:0];
        cnt <= cnt + 6'd1;
      end
      if (state == DONE) begin
        o_data <= ovf_r ? BCD_ERR : bcd_r;
        o_ovf <= ovf_r;
      end
    end
  end
endmodule

// File: tb/tb_seg7_bin2bcd.sv
// tb_seg7_bin2bcd: randomized checks of seg7_bin2bcd against a decimal-arithmetic model
module tb_seg7_bin2bcd;
  logic clk = 1'b0, reset = 1'b1, i_start = 1'b0;
  logic [31:0] i_bin = '0;
  logic o_busy, o_cs, o_ovf;
  logic [31:0] o_data;
  int n_chk = 0, n_pass = 0;

  seg7_bin2bcd dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_bin(i_bin),
    .o_busy(o_busy), .o_data(o_data), .o_cs(o_cs), .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_bcd(input logic [31:0] v);
    longint unsigned x = v;
    logic [31:0] r = '0;
    if (x >= 100_000_000) return 32'hEEEE_EEEE;
    for (int i = 0; i < 8; i++) begin
      r[4*i+:4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic start(input logic [31:0] v);
    @(negedge clk);
    i_start = 1'b1;
    i_bin = v;
    @(posedge clk);
    #1 i_start = 1'b0;
    i_bin = $urandom;
  endtask

  // edges after the start edge until o_cs is seen; -1 if it never arrives
  task automatic wait_cs(output int lat, output int busy_err);
    lat = -1;
    busy_err = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      if (o_cs) begin
        lat = c;
        break;
      end
      if (!o_busy) busy_err++;
    end
  endtask

  task automatic run(input logic [31:0] v);
    int lat, be;
    logic [31:0] exp_data;
    exp_data = ref_bcd(v);
    start(v);
    wait_cs(lat, be);
    check($sformatf("lat %0d", v), lat, 33);
    check($sformatf("busy %0d", v), be, 0);
    check($sformatf("data %0d", v), o_data, exp_data);
    check($sformatf("ovf %0d", v), {31'd0, o_ovf}, {31'd0, v >= 32'd100_000_000});
    check($sformatf("idle %0d", v), {31'd0, o_busy}, 0);
    @(posedge clk);
    #1;
    check($sformatf("cs_drop %0d", v), {31'd0, o_cs}, 0);
    check($sformatf("hold %0d", v), o_data, exp_data);
  endtask

  initial begin
    logic [32:0] acc;
    int lat, be, pulses;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    acc = '0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      acc |= {o_busy, o_cs ^ o_ovf, o_data | {31'd0, o_cs | o_ovf}};
    end
    check("reset_idle", acc[31:0] | {31'd0, acc[32]}, 0);

    run(0);
    run(12_345_678);
    run(99_999_999);
    run(100_000_000);
    run(32'hFFFF_FFFF);
    for (int k = 0; k < 12; k++)
      run(k[0] ? $urandom : 32'($urandom_range(0, 99_999_999)));

    // starts during a conversion are ignored
    start(42);
    pulses = 0;
    lat = -1;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk);
      #1;
      i_start = (c == 5 || c == 20);
      i_bin = 7;
      if (o_cs) begin
        pulses++;
        if (lat < 0) lat = c;
      end
    end
    i_start = 1'b0;
    check("ign_pulses", pulses, 1);
    check("ign_lat", lat, 33);
    check("ign_data", o_data, 32'h0000_0042);

    // a start in the strobe cycle is accepted
    start(100);
    wait_cs(lat, be);
    check("b2b_first", o_data, 32'h0000_0100);
    i_start = 1'b1;
    i_bin = 200;
    @(posedge clk);
    #1 i_start = 1'b0;
    wait_cs(lat, be);
    check("b2b_lat", lat, 33);
    check("b2b_data", o_data, 32'h0000_0200);

    // reset mid-conversion aborts without a strobe
    start(55);
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_abort", {o_busy, o_cs, o_ovf, o_data[28:0]}, 0);
    check("rst_data", o_data, 0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (o_cs || o_busy) pulses++;
    end
    check("rst_no_cs", pulses, 0);
    run(55);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
